// File: rtl/gen_arb_pkg.sv
// Shared state encoding, width/timeout defaults and index helper for gen_arbiter.
package gen_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_TIMEOUT_CYC = 1024;

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search: first asserted request at or after ptr,
// wrapping modulo NUM_REQ; returns a one-hot grant and its index.
module rr_arbiter
  import gen_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic             found;
  logic [IDX_W-1:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      k = IDX_W'((32'(ptr) + off) % NUM_REQ);
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/gen_arbiter.sv
// Shares one sequence generator among NUM_REQ requesters, forwarding its tagged result
// stream. Define GEN_ARB_TIMEOUT_EN to add the BUSY watchdog (TIMEOUT_CYC, rsp_err, gen_abort).
module gen_arbiter
  import gen_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DEF_DATA_W
`ifdef GEN_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_n,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            rsp_valid,
  output logic                            rsp_done,
  output logic [DATA_W-1:0]               rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
  input  logic                            rsp_ready,
  output logic [DATA_W-1:0]               gen_n,
  output logic                            gen_start,
  output logic                            gen_ready,
  input  logic                            gen_valid,
  input  logic                            gen_done,
  input  logic [DATA_W-1:0]               gen_out
`ifdef GEN_ARB_TIMEOUT_EN
  ,
  output logic                            rsp_err,
  output logic                            gen_abort
`endif
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     cur_id;
  logic [DATA_W-1:0]   cur_n;
  logic                rst_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     win_idx;
  logic                any_req;
  logic                quiet;
  logic                busy;
  logic                fwd;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (any_req)
  );

  // Outputs stay silent during reset and the cycle after, so a grant can't fire
  // while the arbiter still holds pre-reset state.
  assign quiet = reset | rst_d;
  assign busy  = (state == BUSY) && !quiet;

  assign req_ready = ((state == IDLE) && !quiet) ? grant : '0;
  assign gen_start = (state == START) && !quiet;
  assign gen_n     = quiet ? '0 : cur_n;
  assign rsp_id    = busy ? cur_id : '0;

`ifdef GEN_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;
  logic             abort_q;
  logic             timed_out;
  logic             err_beat;

  assign timed_out = (cnt == CNT_W'(TIMEOUT_CYC));
  // Once the watchdog fires the generator is disconnected; the error beat is
  // synthesised locally and the following cycle carries the abort pulse.
  assign fwd       = busy && !timed_out && !abort_q;
  assign err_beat  = busy && timed_out && !abort_q;
  assign rsp_valid = (fwd && gen_valid) || err_beat;
  assign rsp_done  = (fwd && gen_done) || err_beat;
  assign rsp_err   = err_beat;
  assign gen_abort = busy && abort_q;
`else
  assign fwd       = busy;
  assign rsp_valid = fwd && gen_valid;
  assign rsp_done  = fwd && gen_done;
`endif

  assign rsp_data  = fwd ? gen_out : '0;
  assign gen_ready = fwd && rsp_ready;

  always_ff @(posedge clock) begin
    rst_d <= reset;
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cur_id <= '0;
      cur_n  <= '0;
`ifdef GEN_ARB_TIMEOUT_EN
      cnt     <= '0;
      abort_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req && !rst_d) begin
            cur_id <= win_idx;
            cur_n  <= req_n[win_idx];
            state  <= START;
          end
        end
        START: begin
          state <= BUSY;
`ifdef GEN_ARB_TIMEOUT_EN
          cnt     <= '0;
          abort_q <= 1'b0;
`endif
        end
        BUSY: begin
`ifdef GEN_ARB_TIMEOUT_EN
          if (abort_q) begin
            abort_q <= 1'b0;
            state   <= IDLE;
            rr_ptr  <= ID_W'(next_idx(32'(cur_id), NUM_REQ));
          end else if (timed_out) begin
            if (rsp_ready) abort_q <= 1'b1;
          end else begin
            if (gen_valid) cnt <= '0;
            else           cnt <= cnt + 1'b1;
            if (gen_valid && gen_done && rsp_ready) begin
              state  <= IDLE;
              rr_ptr <= ID_W'(next_idx(32'(cur_id), NUM_REQ));
            end
          end
`else
          if (gen_valid && gen_done && rsp_ready) begin
            state  <= IDLE;
            rr_ptr <= ID_W'(next_idx(32'(cur_id), NUM_REQ));
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_arbiter.sv
// Directed bench for gen_arbiter with a behavioural generator (argument n -> beats 1..n,
// n=0 -> single zero beat); arguments with the top bit set leave the generator silent.
`timescale 1ns/1ps
module tb_gen_arbiter;
  import gen_arb_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ID_W    = 2;

  logic                           clock = 1'b0;
  logic                           reset;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_n;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           rsp_valid, rsp_done, rsp_ready;
  logic [DATA_W-1:0]              rsp_data;
  logic [ID_W-1:0]                rsp_id;
  logic [DATA_W-1:0]              gen_n, gen_out;
  logic                           gen_start, gen_ready, gen_valid, gen_done;
  logic                           rsp_err, gen_abort;

  always #5 clock = ~clock;

  gen_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W)
`ifdef GEN_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (8)
`endif
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_n     (req_n),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_done  (rsp_done),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .gen_n     (gen_n),
    .gen_start (gen_start),
    .gen_ready (gen_ready),
    .gen_valid (gen_valid),
    .gen_done  (gen_done),
    .gen_out   (gen_out)
`ifdef GEN_ARB_TIMEOUT_EN
    ,
    .rsp_err   (rsp_err),
    .gen_abort (gen_abort)
`endif
  );

`ifndef GEN_ARB_TIMEOUT_EN
  assign rsp_err   = 1'b0;
  assign gen_abort = 1'b0;
`endif

  // Generator model
  logic              g_act = 1'b0;
  logic [DATA_W-1:0] g_n, g_k;

  always @(posedge clock) begin
    if (reset || gen_abort) g_act <= 1'b0;
    else if (gen_start) begin
      g_act <= !gen_n[DATA_W-1];
      g_n   <= gen_n;
      g_k   <= (gen_n == '0) ? '0 : DATA_W'(1);
    end else if (g_act && gen_ready) begin
      if (gen_done) g_act <= 1'b0;
      else          g_k   <= g_k + 1'b1;
    end
  end

  assign gen_valid = g_act;
  assign gen_out   = g_act ? g_k : '0;
  assign gen_done  = g_act && (g_k == g_n || g_n == '0);

  // Monitors
  typedef struct packed {
    logic [31:0]       cyc;
    logic [ID_W-1:0]   id;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t       beats[$];
  int          grants[$];
  logic [31:0] starts[$];
  logic [31:0] aborts[$];
  logic [31:0] cyc = '0;
  int          gr_bad = 0;
  int          stall_seen = 0;
  int          nerr = 0;
  int          nchk = 0;
  logic [3:0]  rdy_pat = 4'b1111;

  function automatic int idx_of(input logic [NUM_REQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic outs_any();
    return |{req_ready, rsp_valid, rsp_done, rsp_data, rsp_id, rsp_err,
             gen_n, gen_start, gen_ready, gen_abort};
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rsp_valid && rsp_ready)
      beats.push_back('{cyc: cyc, id: rsp_id, done: rsp_done, err: rsp_err, data: rsp_data});
    if (|req_ready) grants.push_back(idx_of(req_ready));
    if (gen_start)  starts.push_back(cyc);
    if (gen_abort)  aborts.push_back(cyc);
    if (gen_valid && !reset) begin
      if (gen_ready !== rsp_ready) gr_bad <= gr_bad + 1;
      if (!rsp_ready) stall_seen <= stall_seen + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_logs();
    beats.delete();
    grants.delete();
    starts.delete();
    aborts.delete();
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    clear_logs();
  endtask

  // Runs n cycles; granted requesters drop req_valid unless keep is set.
  task automatic run(input int unsigned n, input bit keep);
    logic [NUM_REQ-1:0] hs;
    for (int unsigned c = 0; c < n; c++) begin
      @(negedge clock);
      hs = req_ready;
      @(posedge clock); #1;
      if (!keep) req_valid = req_valid & ~hs;
      rsp_ready = rdy_pat[2'(c % 4)];
    end
  endtask

  task automatic check_seq(input string tag, input int unsigned n, input logic [ID_W-1:0] id);
    int unsigned nb = (n == 0) ? 1 : n;
    check({tag, "_count"}, 64'(beats.size()), 64'(nb));
    for (int unsigned i = 0; i < nb && i < beats.size(); i++)
      check({tag, "_beat"},
            64'({beats[i].id, beats[i].done, beats[i].err, beats[i].data}),
            64'({id, (i == nb - 1), 1'b0, (n == 0) ? 32'd0 : 32'(i + 1)}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit found;
    logic [NUM_REQ-1:0] hs;
    int exp_g[5] = '{0, 1, 2, 3, 0};

    reset = 1'b1;
    rsp_ready = 1'b1;
    req_n = '0;
    req_valid = 4'b0001;
    req_n[0] = 3;

    // Reset quiet window, then single job n=3 from requester 0
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_outs", 64'(outs_any()), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_outs", 64'(outs_any()), 64'd0);
    @(negedge clock);
    check("t1_grant", 64'(req_ready), 64'b0001);
    @(posedge clock); #1;
    req_valid = '0;
    @(negedge clock);
    check("t1_start", 64'(gen_start), 64'd1);
    check("t1_gen_n", 64'(gen_n), 64'd3);
    @(posedge clock); #1;
    run(6, 1'b0);
    check_seq("t1", 3, 2'd0);
    check("t1_rr_ptr", 64'(dut.rr_ptr), 64'd1);
    check("t1_idle", 64'(dut.state), 64'(IDLE));
    check("t1_starts", 64'(starts.size()), 64'd1);

    // All four requesting continuously, n=1 each
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) req_n[i] = 1;
    req_valid = 4'b1111;
    for (int c = 0; c < 60 && grants.size() < 5; c++) begin
      @(negedge clock); #1;
    end
    @(posedge clock); #1;
    req_valid = '0;
    run(4, 1'b0);
    check("t2_grant_count", 64'(grants.size()), 64'd5);
    check("t2_beat_count", 64'(beats.size()), 64'd5);
    for (int i = 0; i < 5 && i < grants.size() && i < beats.size(); i++) begin
      check("t2_grant_order", 64'(grants[i]), 64'(exp_g[i]));
      check("t2_beat", 64'({beats[i].id, beats[i].done, beats[i].data}),
            64'({2'(exp_g[i]), 1'b1, 32'd1}));
    end

    // Backpressure 1,0,0,1 on a 4-beat job
    do_reset();
    req_n[0] = 4;
    req_valid = 4'b0001;
    rdy_pat = 4'b1001;
    run(24, 1'b0);
    rdy_pat = 4'b1111;
    rsp_ready = 1'b1;
    check_seq("t3", 4, 2'd0);
    check("t3_gen_ready_mirror", 64'(gr_bad), 64'd0);
    check("t3_stall_seen", 64'(stall_seen > 0), 64'd1);

    // Reset after beat 2 of a 5-beat job
    do_reset();
    req_n[0] = 5;
    req_valid = 4'b0001;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clock); #1;
      hs = req_ready;
      found = (beats.size() >= 2);
      @(posedge clock); #1;
      req_valid = req_valid & ~hs;
    end
    check("t4_reached_beat2", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("t4_rst_outs", 64'(outs_any()), 64'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("t4_post_rst_outs", 64'(outs_any()), 64'd0);
    check("t4_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    check("t4_idle", 64'(dut.state), 64'(IDLE));
    @(posedge clock); #1;
    run(6, 1'b0);
    check("t4_beat_count", 64'(beats.size()), 64'd2);
    if (beats.size() >= 2)
      check("t4_beat2", 64'({beats[1].done, beats[1].data}), 64'({1'b0, 32'd2}));

    // Zero-length job from requester 2, no reset in between
    clear_logs();
    req_n[2] = 0;
    req_valid = 4'b0100;
    run(6, 1'b0);
    check_seq("t5", 0, 2'd2);
    check("t5_rr_ptr", 64'(dut.rr_ptr), 64'd3);
    if (beats.size() >= 1 && starts.size() >= 1)
      check("t5_latency", 64'(beats[0].cyc - starts[0]), 64'd1);

`ifdef GEN_ARB_TIMEOUT_EN
    // Silent generator: watchdog error beat, abort pulse, next requester
    do_reset();
    req_n[0] = 32'h8000_0000;
    req_n[1] = 1;
    req_valid = 4'b0011;
    run(24, 1'b0);
    check("t6_grant_count", 64'(grants.size()), 64'd2);
    if (grants.size() >= 2) check("t6_next_grant", 64'(grants[1]), 64'd1);
    check("t6_beat_count", 64'(beats.size()), 64'd2);
    check("t6_abort_count", 64'(aborts.size()), 64'd1);
    if (beats.size() >= 2 && starts.size() >= 1 && aborts.size() >= 1) begin
      check("t6_err_beat", 64'({beats[0].id, beats[0].done, beats[0].err, beats[0].data}),
            64'({2'd0, 1'b1, 1'b1, 32'd0}));
      check("t6_err_delay", 64'(beats[0].cyc - starts[0]), 64'd9);
      check("t6_abort_delay", 64'(aborts[0] - starts[0]), 64'd10);
      check("t6_next_beat", 64'({beats[1].id, beats[1].done, beats[1].err, beats[1].data}),
            64'({2'd1, 1'b1, 1'b0, 32'd1}));
    end
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/gen_arbiter.md
GEN_ARBITER -- requirements
Module: gen_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one generator (2..16).
REQ-002 SHALL have parameter DATA_W, default 32: width of argument and result words.
REQ-003 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester job request.
REQ-006 SHALL have port req_n  input  NUM_REQ x DATA_W  per-requester generator argument.
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot job-accept pulse.
REQ-008 SHALL have port rsp_valid, rsp_done, rsp_data, rsp_id  output  1,1,DATA_W,clog2(NUM_REQ)  tagged result stream.
REQ-009 SHALL have port rsp_ready  input  1  downstream backpressure.
REQ-010 SHALL have port gen_n, gen_start  output  DATA_W,1  argument and start to the generator.
REQ-011 SHALL have port gen_ready  output  1  backpressure to the generator.
REQ-012 SHALL have port gen_valid, gen_done, gen_out  input  1,1,DATA_W  generator result handshake.

Function
REQ-013 SHALL implement states IDLE, START, BUSY.
REQ-014 IDLE: if any req_valid, SHALL grant round-robin winner starting at pointer rr_ptr, pulse req_ready[winner] for one cycle, latch req_n and id, and go to START.
REQ-015 IDLE with no req_valid SHALL remain in IDLE, with all req_ready low.
REQ-016 START SHALL drive gen_start=1 and gen_n=latched argument for exactly one cycle, then go to BUSY.
REQ-017 gen_n SHALL hold the latched argument in START and BUSY.
REQ-018 BUSY SHALL forward combinationally (zero latency): rsp_valid=gen_valid, rsp_done=gen_done, rsp_data=gen_out, rsp_id=latched id, gen_ready=rsp_ready.
REQ-019 Outside BUSY, SHALL drive rsp_valid=0 and gen_ready=0.
REQ-020 The cycle with gen_valid & gen_done & rsp_ready in BUSY SHALL return to IDLE and set rr_ptr=(winner+1) mod NUM_REQ.
REQ-021 A beat is transferred only when rsp_valid & rsp_ready; results from a stalled generator are never dropped or duplicated.
REQ-022 Requesters hold req_valid and req_n until req_ready; any requester with req_valid held SHALL be granted within NUM_REQ jobs.
REQ-023 Changes to req_valid during START/BUSY SHALL have no effect until the next IDLE.
REQ-024 A job whose first beat carries done (zero-length result) SHALL complete in one BUSY beat.
REQ-025 Minimum job turnaround SHALL be 3 cycles (IDLE, START, one BUSY beat).

Reset
REQ-026 reset SHALL force IDLE, rr_ptr=0, latched id=0, latched argument=0.
REQ-027 While reset is high and one cycle after, all outputs SHALL be 0, including req_ready, rsp_*, gen_start, gen_ready.
REQ-028 Reset mid-job SHALL abandon the job silently, with no rsp beat.
REQ-029 The generator SHALL share the same reset.

Configuration
REQ-030 With GEN_ARB_TIMEOUT_EN defined, SHALL add parameter TIMEOUT_CYC (default 1024), outputs rsp_err (1) and gen_abort (1), and a watchdog counter cleared on every gen_valid and on entry to BUSY.
REQ-031 When the counter reaches TIMEOUT_CYC in BUSY, SHALL emit one beat with rsp_valid=1, rsp_done=1, rsp_err=1 and rsp_data=0, held until rsp_ready, then pulse gen_abort for one cycle and go to IDLE with rr_ptr advanced.
REQ-032 Without GEN_ARB_TIMEOUT_EN, rsp_err, gen_abort, the counter and TIMEOUT_CYC SHALL not exist, and BUSY waits indefinitely.

Structure
REQ-033 Package gen_arb_pkg SHALL hold the state enum (IDLE, START, BUSY), the default DATA_W, and the default TIMEOUT_CYC.
REQ-034 The winner search SHALL be a sub-module rr_arbiter: purely combinational, NUM_REQ request vector plus pointer in, one-hot grant and index out.

Verification
Bench generator model: for argument n, emits n beats with data 1..n, done on the last beat; n=0 emits one beat with data 0 and done.

REQ-035 SHALL cover: req_valid=0001, req_n[0]=3, rsp_ready=1 -> gen_start one cycle later; beats 1,2,3 with rsp_id=0, done on 3; back in IDLE; rr_ptr=1.
REQ-036 SHALL cover: req_valid=1111 held, all n=1 -> grant order 0,1,2,3,0; each job returns a single beat with the matching rsp_id.
REQ-037 SHALL cover: n=4, rsp_ready toggling 1,0,0,1,... -> exactly beats 1,2,3,4 with no loss or duplicate; gen_ready mirrors rsp_ready.
REQ-038 SHALL cover: reset asserted after beat 2 of an n=5 job -> no further rsp beats, IDLE, rr_ptr=0, all outputs 0.
REQ-039 SHALL cover: req_valid[2] with n=0 -> one beat, data 0, done=1, rsp_id=2.
REQ-040 SHALL cover, with GEN_ARB_TIMEOUT_EN and TIMEOUT_CYC=8: generator silent after start -> error beat with rsp_err=1 and data 0 after 8 BUSY cycles, then one gen_abort pulse, then the next requester is granted.
